// File: rtl/uart_tx.sv
// UART serializer: accepts a word over valid/ready and shifts out
// start, LSB-first data, optional parity and stop bits on tx_sig.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_sig,
    output logic                  tx_busy
);

    localparam int unsigned PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW          = $clog2(STOP_BITS * PULSE_WIDTH) + 1;
    localparam int unsigned BW          = $clog2(DATA_WIDTH) + 1;

    if (PULSE_WIDTH < 2) begin : g_bad_pulse
        $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_tx: DATA_WIDTH must be 5..9");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic [CW-1:0]         cnt;
    logic                  par_bit;
    logic                  cnt_zero;
    logic                  last_bit;

    assign cnt_zero = (cnt == '0);
    assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (tx_valid) state_nxt = S_START;
            S_START:  if (cnt_zero) state_nxt = S_DATA;
            S_DATA:   if (cnt_zero && last_bit) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (cnt_zero) state_nxt = S_STOP;
            S_STOP:   if (cnt_zero) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath: word capture, bit shifting and per-bit cycle countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg   <= tx_data;
                        par_bit <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                        cnt     <= CW'(PULSE_WIDTH - 1);
                        bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (cnt_zero) begin
                        cnt     <= CW'(PULSE_WIDTH - 1);
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_zero) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        // Last data bit without parity goes straight into the stop phase
                        cnt     <= (last_bit && PARITY == 0) ? CW'(STOP_BITS * PULSE_WIDTH - 1)
                                                             : CW'(PULSE_WIDTH - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_zero) begin
                        cnt <= CW'(STOP_BITS * PULSE_WIDTH - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_STOP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        tx_sig   = 1'b1;
        tx_ready = 1'b0;
        tx_busy  = 1'b1;
        case (state)
            S_IDLE: begin
                tx_ready = 1'b1;
                tx_busy  = 1'b0;
            end
            S_START:  tx_sig = 1'b0;
            S_DATA:   tx_sig = shreg[0];
            S_PARITY: tx_sig = par_bit;
            S_STOP:   tx_sig = 1'b1;
            default:  tx_sig = 1'b1;
        endcase
    end

endmodule
